// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_pkg
//  Description : Shared types and constants for the SCCB register loader.
//  Revision    : 1.0  initial release
// ============================================================================
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_SEND,
        ST_STOP,
        ST_GAP,
        ST_WAIT,
        ST_FIN
    } sccb_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sccb_entry_t;

    localparam logic [15:0] c_sentinel   = 16'hFFFF;
    localparam logic [7:0]  c_delay_mark = 8'hFF;

    // 27-bit write frame; every 9th bit is a released ACK slot.
    function automatic logic [26:0] sccb_frame(input logic [7:0] dev, input sccb_entry_t e);
        return {dev, 1'b1, e.addr, 1'b1, e.data, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_cfg_rom.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_cfg_rom
//  Description : Combinational OV7670 init table, {addr,data} per index.
//  Revision    : 1.0  initial release
// ============================================================================
module ov7670_cfg_rom
    import sccb_pkg::*;
(
    input  logic [7:0]  idx,
    output logic [15:0] entry
);

    always_comb begin
        entry = c_sentinel;
        case (idx)
            8'd0:    entry = 16'h1280;  // COM7 soft reset
            8'd1:    entry = 16'hFF00;  // settle after reset
            8'd2:    entry = 16'h1204;  // COM7 RGB output
            8'd3:    entry = 16'h40D0;  // COM15 RGB565 full range
            8'd4:    entry = 16'h3A04;
            8'd5:    entry = 16'h8C00;
            8'd6:    entry = 16'h1713;
            8'd7:    entry = 16'h1801;
            default: entry = c_sentinel;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sccb_config.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_config
//  Description : Walks the OV7670 init ROM and writes each entry over SCCB.
//                Optional ACK checking enabled by macro SCCB_ACK_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module sccb_config
    import sccb_pkg::*;
#(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         SCCB_HZ  = 100_000,
    parameter logic [7:0] DEV_ID   = 8'h42,
    parameter int         DELAY_MS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       siod_in,
    output logic       sioc,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic [7:0] reg_idx
);

    localparam int          c_qtr        = CLK_HZ / (4 * SCCB_HZ);
    localparam logic [15:0] c_qtr_last   = 16'(c_qtr - 1);
    localparam int          c_delay      = (DELAY_MS * CLK_HZ) / 1000;
    localparam logic [31:0] c_delay_last = 32'(c_delay - 1);

    sccb_state_t r_state;
    logic        r_sioc, r_oe, r_busy, r_done, r_nack;
    logic [7:0]  r_idx;
    logic [15:0] r_div;
    logic [1:0]  r_q;
    logic [4:0]  r_bit;
    logic [26:0] r_shift;
    logic [31:0] r_wait;

    logic [15:0] w_rom;
    sccb_entry_t w_entry;
    logic        w_tick;

    ov7670_cfg_rom u_rom (
        .idx   (r_idx),
        .entry (w_rom)
    );

    assign w_entry = w_rom;
    assign w_tick  = (r_div == c_qtr_last);

`ifdef SCCB_ACK_CHECK_EN
    logic w_ack_slot;
    assign w_ack_slot = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);
`else
    logic w_unused_siod;
    assign w_unused_siod = siod_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sioc  <= 1'b1;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_idx   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_wait  <= '0;
        end else begin
            // Quarter-bit divider restarts whenever a new frame is about to begin.
            if ((r_state inside {ST_IDLE, ST_LOAD, ST_FIN}) || w_tick)
                r_div <= '0;
            else
                r_div <= r_div + 16'd1;

            case (r_state)
                ST_IDLE, ST_FIN: begin
                    r_sioc <= 1'b1;
                    r_oe   <= 1'b0;
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_nack  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_sioc <= 1'b1;
                    r_oe   <= 1'b0;
                    r_q    <= '0;
                    r_bit  <= '0;
                    r_wait <= '0;
                    if (w_entry == c_sentinel || r_idx == 8'hFF) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_entry.addr == c_delay_mark) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_START;
                        r_shift <= sccb_frame(DEV_ID, w_entry);
                    end
                end
                ST_START: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0: r_oe   <= 1'b1;
                        2'd1: r_sioc <= 1'b0;
                        default: begin
                            r_state <= ST_SEND;
                            r_q     <= '0;
                            r_oe    <= ~r_shift[26];
                        end
                    endcase
                end
                ST_SEND: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0: r_sioc <= 1'b1;
                        2'd1: begin
`ifdef SCCB_ACK_CHECK_EN
                            if (w_ack_slot && siod_in)
                                r_nack <= 1'b1;
`endif
                        end
                        2'd2: r_sioc <= 1'b0;
                        default: begin
                            if (r_bit == 5'd26 || r_nack) begin
                                r_state <= ST_STOP;
                                r_oe    <= 1'b1;
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_shift <= r_shift << 1;
                                r_oe    <= ~r_shift[25];
                            end
                        end
                    endcase
                end
                ST_STOP: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0: r_sioc <= 1'b1;
                        2'd1: r_oe   <= 1'b0;
                        default: begin
                            r_q <= '0;
                            if (r_nack) begin
                                r_state <= ST_FIN;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end
                    endcase
                end
                ST_GAP: if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        r_state <= ST_LOAD;
                        r_idx   <= r_idx + 8'd1;
                    end
                end
                ST_WAIT: begin
                    r_wait <= r_wait + 32'd1;
                    if (r_wait == c_delay_last) begin
                        r_state <= ST_LOAD;
                        r_idx   <= r_idx + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sioc     = r_sioc;
    assign siod_oe  = r_oe;
    assign busy     = r_busy;
    assign done     = r_done;
    assign nack_err = r_nack;
    assign reg_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_sccb_config.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_config
//  Description : Scoreboard bench: decodes the SCCB bus and compares each
//                write against a table walk model of the init ROM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sccb_config;

    localparam int         CLK_HZ    = 1_000_000;
    localparam int         SCCB_HZ   = 125_000;
    localparam int         DELAY_MS  = 1;
    localparam logic [7:0] DEV_ID    = 8'h42;
    localparam int         QTR       = CLK_HZ / (4 * SCCB_HZ);
    localparam int         BIT_CYC   = 4 * QTR;
    localparam int         DELAY_CYC = DELAY_MS * CLK_HZ / 1000;
`ifdef SCCB_ACK_CHECK_EN
    localparam bit ACK_MODE = 1'b1;
`else
    localparam bit ACK_MODE = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, siod_in = 1'b0;
    logic       sioc, siod_oe, busy, done, nack_err;
    logic [7:0] reg_idx;

    sccb_config #(.CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .DEV_ID(DEV_ID), .DELAY_MS(DELAY_MS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .siod_in  (siod_in),
        .sioc     (sioc),
        .siod_oe  (siod_oe),
        .busy     (busy),
        .done     (done),
        .nack_err (nack_err),
        .reg_idx  (reg_idx)
    );

    always #5 clk = ~clk;

    // gap: 0 = unchecked, 1 = normal inter-frame gap, 2 = follows a delay entry
    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic [7:0] data;
        int         nbits;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   last_idx = 0;

    function automatic logic [15:0] tbl(input int i);
        case (i)
            0: return 16'h1280;
            1: return 16'hFF00;
            2: return 16'h1204;
            3: return 16'h40D0;
            4: return 16'h3A04;
            5: return 16'h8C00;
            6: return 16'h1713;
            7: return 16'h1801;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference walk: what the bus should carry for one start pulse.
    task automatic plan_walk(input bit nack);
        bit         pend  = 1'b0;
        bit         first = 1'b1;
        logic [15:0] e;
        for (int i = 0; i < 255; i++) begin
            e = tbl(i);
            last_idx = i;
            if (e == 16'hFFFF) return;
            if (e[15:8] == 8'hFF) begin
                pend = 1'b1;
                continue;
            end
            exp_q.push_back('{i, e[15:8], e[7:0], nack ? 9 : 27, first ? 0 : (pend ? 2 : 1)});
            if (nack) return;
            first = 1'b0;
            pend  = 1'b0;
        end
        last_idx = 255;
    endtask

    // Bus monitor: START/STOP with SIOC high, data sampled on SIOC rise.
    int          cyc = 0, nb = 0, last_edge = 0, last_rise = 0, quiet = 0, per_seen = BIT_CYC;
    logic        p_sc = 1'b1, p_sd = 1'b1;
    bit          in_tx = 1'b0;
    logic [27:0] bits = '0;

    always @(negedge clk) begin : mon
        logic sc, sd;
        exp_t e;
        cyc++;
        sc = sioc;
        sd = ~siod_oe;
        if (!rst_n) begin
            in_tx = 1'b0;
            nb    = 0;
        end else begin
            if (p_sc && sc && p_sd && !sd) begin
                if (in_tx) check("repeated_start", 1, 0);
                in_tx = 1'b1; nb = 0; bits = '0; per_seen = BIT_CYC;
                quiet = cyc - last_edge;
            end else if (in_tx && p_sc && sc && !p_sd && sd) begin
                in_tx = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    // the STOP's own SIOC pulse was shifted in as a trailing 0
                    check("tx_len", nb - 1, e.nbits);
                    if (e.nbits == 27) check("tx_bits", {5'b0, bits[27:1]}, {5'b0, DEV_ID, 1'b1, e.addr, 1'b1, e.data, 1'b1});
                    else               check("tx_bits", {23'b0, bits[9:1]}, {23'b0, DEV_ID, 1'b1});
                    check("tx_reg_idx", reg_idx, e.idx);
                    check("bit_period", per_seen, BIT_CYC);
                    if (e.gap == 1) check_range("gap_normal", quiet, BIT_CYC, DELAY_CYC - 1);
                    if (e.gap == 2) check_range("gap_delay", quiet, DELAY_CYC, DELAY_CYC + 16 * QTR);
                end
            end else if (in_tx && !p_sc && sc) begin
                if (nb > 0 && (cyc - last_rise) != BIT_CYC && per_seen == BIT_CYC) per_seen = cyc - last_rise;
                last_rise = cyc;
                bits = {bits[26:0], sd};
                nb++;
            end
            if (sc != p_sc) last_edge = cyc;
        end
        p_sc = sc;
        p_sd = sd;
    end

    task automatic pulse_start();
        repeat ($urandom_range(1, 20)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("nack_cleared", nack_err, 0);
    endtask

    task automatic wait_done(input bit spurious, input bit rand_siod);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            start = spurious && busy && ($urandom_range(0, 199) == 0);
            if (rand_siod) siod_in = 1'($urandom_range(0, 1));
            n++;
        end
        start = 1'b0;
        check("done_within_bound", done, 1);
    endtask

    task automatic end_checks(input bit exp_nack);
        @(negedge clk);
        check("fin_busy", busy, 0);
        check("fin_done", done, 1);
        check("fin_nack", nack_err, exp_nack);
        check("fin_reg_idx", reg_idx, last_idx);
        check("fin_bus_idle", {sioc, siod_oe}, 2'b10);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int viol, target, n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sioc", sioc, 1);
        check("rst_siod_oe", siod_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack_err, 0);
        check("rst_reg_idx", reg_idx, 0);
        rst_n = 1'b1;

        viol = 0;
        repeat (10000) begin
            @(negedge clk);
            if (sioc !== 1'b1 || siod_oe !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("idle_hold_violations", viol, 0);

        // Walk 1 with siod_in stuck high: a NACK only matters when checking is built in.
        siod_in = 1'b1;
        plan_walk(ACK_MODE);
        pulse_start();
        wait_done(1'b0, 1'b0);
        end_checks(ACK_MODE);
        siod_in = 1'b0;

        // Walk 2: rewalk from index 0 with ignored start pulses while busy.
        plan_walk(1'b0);
        pulse_start();
        wait_done(1'b1, !ACK_MODE);
        end_checks(1'b0);
        siod_in = 1'b0;

        // Walk 3: reset lands inside the address phase of the first frame.
        plan_walk(1'b0);
        pulse_start();
        target = 9 + $urandom_range(0, 7);
        n = 0;
        while (!(in_tx && nb == target) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("reached_addr_phase", (in_tx && nb == target), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sioc", sioc, 1);
        check("async_rst_siod_oe", siod_oe, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_reg_idx", reg_idx, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);

        // Release and start in the same cycle; the start must be honoured.
        plan_walk(1'b0);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_release", busy, 1);
        wait_done(1'b1, !ACK_MODE);
        end_checks(1'b0);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sccb_config.md
SCCB_CONFIG -- requirements
Module: sccb_config

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, system clock frequency.
REQ-002 Parameter SCCB_HZ, 100_000, SIOC bit rate.
REQ-003 Parameter DEV_ID, 8'h42, camera write address (7-bit ID plus write bit).
REQ-004 Parameter DELAY_MS, 10, pause length for a delay table entry.
REQ-005 clk  input  1  system clock; all logic on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle pulse that begins walking the register table.
REQ-008 siod_in  input  1  sampled SIOD pad level.
REQ-009 sioc  output  1  SCCB clock, driven push-pull.
REQ-010 siod_oe  output  1  1 means drive SIOD low; 0 releases SIOD to the pull-up (open-drain).
REQ-011 busy  output  1  high from the cycle after start until done.
REQ-012 done  output  1  sticky; set when the table end is reached, cleared by the next start.
REQ-013 nack_err  output  1  sticky ACK-failure flag (see REQ-030).
REQ-014 reg_idx  output  8  index of the table entry currently being sent.

Function
REQ-015 Timing base: quarter-bit tick every CLK_HZ/(4*SCCB_HZ) cycles (125 at defaults), from a free-running divider that is reset while IDLE.
REQ-016 Bit cell is 4 quarters: Q0 SIOC low, SIOD updated; Q1 and Q2 SIOC high; Q3 SIOC low.
REQ-017 States: IDLE, LOAD, START, SEND, STOP, GAP, WAIT, FIN.
REQ-018 IDLE: start=1 -> LOAD with reg_idx=0. start is ignored outside IDLE and FIN.
REQ-019 LOAD: read the 16-bit entry {addr,data} at reg_idx.
  - {FF,FF} -> FIN.
  - addr=FF with any other data -> WAIT.
  - otherwise -> START.
REQ-020 START: SIOD released with SIOC high for one quarter; then SIOD low with SIOC high for one quarter; then SIOC low; then SEND.
REQ-021 SEND: three 9-bit phases, MSB first: DEV_ID, addr, data.
  - The 9th bit of each phase releases SIOD (don't-care/ACK slot).
REQ-022 STOP: SIOD low at Q0; SIOC high at Q1; SIOD released at Q2; then GAP.
REQ-023 GAP: hold SIOC high and SIOD released for 4 quarters; then increment reg_idx and go to LOAD.
REQ-024 WAIT: count DELAY_MS*CLK_HZ/1000 cycles; then increment reg_idx and go to LOAD.
REQ-025 FIN: done=1, busy=0; start=1 -> LOAD, clearing done and nack_err.
REQ-026 reg_idx is 8 bits; reaching index 255 without a sentinel forces FIN.
REQ-027 Bus idle level (IDLE, FIN, reset): sioc=1, siod_oe=0.

Reset
REQ-028 rst_n low, asynchronously:
  - state=IDLE, sioc=1, siod_oe=0, busy=0, done=0, nack_err=0, reg_idx=0, divider=0.
  - Asserting it mid-transaction abandons the transfer with no STOP; the camera recovers on the next START.
REQ-029 Deassertion takes effect on the next clk edge; start arriving in that same cycle is honoured.

Configuration
REQ-030 With SCCB_ACK_CHECK_EN defined:
  - siod_in is sampled at the Q1/Q2 boundary of each 9th bit.
  - A sampled 1 sets nack_err, aborts via STOP, then goes to FIN.
  - Without the macro, the 9th bit is ignored, siod_in is unused, and nack_err is tied 0.

Structure
REQ-031 Shared package sccb_pkg holds: the state enum, the sentinel constant 16'hFFFF, the delay marker 8'hFF, and the entry typedef {addr[7:0], data[7:0]}.
REQ-032 Sub-module ov7670_cfg_rom: combinational 8-bit index to 16-bit entry; table begins {12,80} (soft reset), {FF,00} (delay), {12,04} (RGB), ... {FF,FF}.

Verification
REQ-033 Reset release, no start -> sioc=1, siod_oe=0, busy=0 held for 10,000 cycles.
REQ-034 Pulse start, one entry {12,80} -> SIOD bitstream 0x42,X,0x12,X,0x80,X; bit period 500 cycles; START/STOP edges occur with SIOC high.
REQ-035 Delay entry {FF,00} at default parameters -> no SIOC edges for 500,000 cycles ±1 tick; reg_idx then advances.
REQ-036 Full ROM walk -> done=1 and busy=0 after the sentinel; a second start clears done and rewalks from reg_idx=0.
REQ-037 SCCB_ACK_CHECK_EN defined and siod_in held 1 -> nack_err=1 after the first phase, STOP emitted, done=1; without the macro, same stimulus -> nack_err=0 and the full table completes.
REQ-038 rst_n pulsed low during the addr phase -> outputs return to idle within 0 cycles (async); a later start restarts from reg_idx=0.
